// File: rtl/bayer_stream_tx_if.sv
// Bundles the signals between the RGB pixel source, the Bayer transmitter and
// the processing pipeline.
//   Upstream RGB side : iValid, iR, iG, iB (source -> tx), oReady (tx -> source)
//   Downstream Bayer  : oNewFrame, oValid, oData, oDone, oXCnt, oYCnt, oFrameCnt
// master = the environment (pixel source and Bayer sink); slave = the transmitter.
interface bayer_stream_tx_if;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          iValid;
  logic [DW-1:0] iR;
  logic [DW-1:0] iG;
  logic [DW-1:0] iB;
  logic          oReady;

  logic          oNewFrame;
  logic          oValid;
  logic [DW-1:0] oData;
  logic          oDone;
  logic [CW-1:0] oXCnt;
  logic [CW-1:0] oYCnt;
  logic [CW-1:0] oFrameCnt;

  modport master (
    output iValid, iR, iG, iB,
    input  oReady, oNewFrame, oValid, oData, oDone, oXCnt, oYCnt, oFrameCnt
  );

  modport slave (
    input  iValid, iR, iG, iB,
    output oReady, oNewFrame, oValid, oData, oDone, oXCnt, oYCnt, oFrameCnt
  );
endinterface

// File: rtl/bayer_stream_tx.sv
// Converts a full-RGB pixel stream into a sensor-like raw 8-bit Bayer mosaic
// stream with frame/line framing, horizontal and vertical blanking and an
// end-of-frame pulse.
// Ports:
//   clk      clock
//   reset    synchronous, active-high
//   iEnable  allows a new frame to start (sampled in IDLE and at frame end)
//   io_bus   slave side of bayer_stream_tx_if (RGB in, Bayer out)
// oReady is a decode of the state register; all other outputs are registered.
module bayer_stream_tx #(
  parameter int unsigned width   = 1920,
  parameter int unsigned height  = 1080,
  parameter int unsigned hBlank  = 16,
  parameter int unsigned vBlank  = 64,
  parameter int unsigned pattern = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iEnable,
  bayer_stream_tx_if.slave      io_bus
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_VBLANK = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_HBLANK = 2'd3;

  localparam logic [CW-1:0] X_LAST = CW'(width - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(height - 1);
  localparam logic [CW-1:0] V_LAST = CW'(vBlank - 1);
  // HBLANK is never entered when hBlank is 0, so its terminal value is moot then
  localparam logic [CW-1:0] H_LAST = CW'((hBlank == 0) ? 0 : hBlank - 1);
  localparam logic [1:0]    PAT    = 2'(pattern);

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [CW-1:0] r_blank_cnt;
  logic [CW-1:0] w_blank_cnt_next;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          w_accept;
  logic          w_last_col;
  logic          w_last_row;
  logic          w_frame_end;
  logic          w_new_frame;
  logic          w_px;
  logic          w_py;
  logic [DW-1:0] w_data;

  logic          r_new_frame;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_done;
  logic [CW-1:0] r_xcnt;
  logic [CW-1:0] r_ycnt;
  logic [CW-1:0] r_frame_cnt;

  assign w_accept    = (r_state == S_ACTIVE) && io_bus.iValid;
  assign w_last_col  = (r_x == X_LAST);
  assign w_last_row  = (r_y == Y_LAST);
  assign w_frame_end = w_accept && w_last_col && w_last_row;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_blank_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_blank_cnt <= w_blank_cnt_next;
    end
  end

  // Next state and blanking count; the count is zero on entry to any blanking state
  always_comb begin
    w_next_state     = r_state;
    w_blank_cnt_next = '0;
    case (r_state)
      S_IDLE: begin
        if (iEnable) w_next_state = S_VBLANK;
      end
      S_VBLANK: begin
        if (r_blank_cnt == V_LAST) w_next_state = S_ACTIVE;
        else                       w_blank_cnt_next = r_blank_cnt + CW'(1);
      end
      S_ACTIVE: begin
        if (w_accept && w_last_col) begin
          if (!w_last_row) w_next_state = (hBlank == 0) ? S_ACTIVE : S_HBLANK;
          else             w_next_state = iEnable ? S_VBLANK : S_IDLE;
        end
      end
      S_HBLANK: begin
        if (r_blank_cnt == H_LAST) w_next_state = S_ACTIVE;
        else                       w_blank_cnt_next = r_blank_cnt + CW'(1);
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Look ahead one cycle so the registered pulse lands on the last VBLANK cycle
  assign w_new_frame = (w_next_state == S_VBLANK) && (w_blank_cnt_next == V_LAST);

  // CFA colour select
  assign w_px = r_x[0] ^ PAT[0];
  assign w_py = r_y[0] ^ PAT[1];

  always_comb begin
    w_data = io_bus.iG;
    case ({w_py, w_px})
      2'b00:   w_data = io_bus.iR;
      2'b11:   w_data = io_bus.iB;
      default: w_data = io_bus.iG;
    endcase
  end

  // Pixel position; wraps to the origin at frame end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_x <= '0;
        r_y <= w_last_row ? '0 : r_y + CW'(1);
      end else begin
        r_x <= r_x + CW'(1);
      end
    end
  end

  // Output register, one cycle after accept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_new_frame <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_xcnt      <= '0;
      r_ycnt      <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_new_frame <= w_new_frame;
      r_valid     <= w_accept;
      r_data      <= w_accept ? w_data : '0;
      r_done      <= w_frame_end;
      if (w_accept) begin
        r_xcnt <= r_x;
        r_ycnt <= r_y;
      end
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + CW'(1);
    end
  end

  assign io_bus.oReady    = (r_state == S_ACTIVE);
  assign io_bus.oNewFrame = r_new_frame;
  assign io_bus.oValid    = r_valid;
  assign io_bus.oData     = r_data;
  assign io_bus.oDone     = r_done;
  assign io_bus.oXCnt     = r_xcnt;
  assign io_bus.oYCnt     = r_ycnt;
  assign io_bus.oFrameCnt = r_frame_cnt;

endmodule

// File: tb/tb_bayer_stream_tx.sv
// Bench for bayer_stream_tx: three instances with different geometry / CFA
// phase share one stimulus stream; each is checked every cycle against a
// pixel-index / blanking-countdown reference model, plus directed checks of
// the first frame's sample order.
module tb_bayer_stream_tx;

  localparam int NI = 3;
  localparam int unsigned CFG_W [NI] = '{4, 4, 4};
  localparam int unsigned CFG_H [NI] = '{2, 2, 3};
  localparam int unsigned CFG_HB[NI] = '{2, 2, 0};
  localparam int unsigned CFG_VB[NI] = '{3, 3, 3};
  localparam int unsigned CFG_P [NI] = '{0, 3, 0};

  logic       clk = 1'b0;
  logic       reset;
  logic       tb_en;
  logic       tb_valid;
  logic [7:0] tb_r, tb_g, tb_b;

  logic        obs_ready [NI];
  logic        obs_nf    [NI];
  logic        obs_valid [NI];
  logic [7:0]  obs_data  [NI];
  logic        obs_done  [NI];
  logic [15:0] obs_x     [NI];
  logic [15:0] obs_y     [NI];
  logic [15:0] obs_fc    [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bayer_stream_tx_if u_if ();
    assign u_if.iValid = tb_valid;
    assign u_if.iR     = tb_r;
    assign u_if.iG     = tb_g;
    assign u_if.iB     = tb_b;
    assign obs_ready[g] = u_if.oReady;
    assign obs_nf[g]    = u_if.oNewFrame;
    assign obs_valid[g] = u_if.oValid;
    assign obs_data[g]  = u_if.oData;
    assign obs_done[g]  = u_if.oDone;
    assign obs_x[g]     = u_if.oXCnt;
    assign obs_y[g]     = u_if.oYCnt;
    assign obs_fc[g]    = u_if.oFrameCnt;

    bayer_stream_tx #(
      .width  (CFG_W[g]),
      .height (CFG_H[g]),
      .hBlank (CFG_HB[g]),
      .vBlank (CFG_VB[g]),
      .pattern(CFG_P[g])
    ) u_dut (
      .clk    (clk),
      .reset  (reset),
      .iEnable(tb_en),
      .io_bus (u_if.slave)
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frame scheduled?, blank cycles left, next pixel index
  int m_go   [NI];
  int m_wcnt [NI];
  int m_idx  [NI];
  int m_fc   [NI];
  int e_ready[NI], e_nf[NI], e_valid[NI], e_data[NI], e_done[NI], e_x[NI], e_y[NI];

  bit collect = 1'b0;
  int q_smp [NI][$];

  task automatic chk(input string tag, input int n, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, n, obs, expv);
    end
  endtask

  task automatic model_step(input int n);
    int w, h, x, y, px, py;
    w = int'(CFG_W[n]);
    h = int'(CFG_H[n]);
    e_valid[n] = 0;
    e_done[n]  = 0;
    e_data[n]  = 0;
    if (reset) begin
      m_go[n] = 0; m_wcnt[n] = 0; m_idx[n] = 0; m_fc[n] = 0;
      e_x[n] = 0; e_y[n] = 0;
    end else if (m_go[n] == 0) begin
      if (tb_en) begin
        m_go[n]   = 1;
        m_wcnt[n] = int'(CFG_VB[n]);
      end
    end else if (m_wcnt[n] > 0) begin
      m_wcnt[n]--;
    end else if (tb_valid) begin
      x  = m_idx[n] % w;
      y  = m_idx[n] / w;
      px = (x % 2) ^ int'(CFG_P[n] % 2);
      py = (y % 2) ^ int'(CFG_P[n] / 2);
      if (px == 0 && py == 0)      e_data[n] = int'(tb_r);
      else if (px == 1 && py == 1) e_data[n] = int'(tb_b);
      else                         e_data[n] = int'(tb_g);
      e_valid[n] = 1;
      e_x[n] = x;
      e_y[n] = y;
      m_idx[n]++;
      if (m_idx[n] == w * h) begin
        e_done[n] = 1;
        m_fc[n]   = (m_fc[n] + 1) % 65536;
        m_idx[n]  = 0;
        if (tb_en) m_wcnt[n] = int'(CFG_VB[n]);
        else       m_go[n]   = 0;
      end else if (m_idx[n] % w == 0) begin
        m_wcnt[n] = int'(CFG_HB[n]);
      end
    end
    e_nf[n]    = (m_go[n] == 1 && m_idx[n] == 0 && m_wcnt[n] == 1) ? 1 : 0;
    e_ready[n] = (m_go[n] == 1 && m_wcnt[n] == 0) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int n = 0; n < NI; n++) model_step(n);
    #1;
    for (int n = 0; n < NI; n++) begin
      chk("oReady",    n, int'(obs_ready[n]), e_ready[n]);
      chk("oNewFrame", n, int'(obs_nf[n]),    e_nf[n]);
      chk("oValid",    n, int'(obs_valid[n]), e_valid[n]);
      chk("oData",     n, int'(obs_data[n]),  e_data[n]);
      chk("oDone",     n, int'(obs_done[n]),  e_done[n]);
      chk("oXCnt",     n, int'(obs_x[n]),     e_x[n]);
      chk("oYCnt",     n, int'(obs_y[n]),     e_y[n]);
      chk("oFrameCnt", n, int'(obs_fc[n]),    m_fc[n]);
      if (collect && obs_valid[n]) q_smp[n].push_back(int'(obs_data[n]));
    end
  endtask

  int exp_a [8]  = '{'h10, 'h20, 'h10, 'h20, 'h20, 'h30, 'h20, 'h30};
  int exp_b [8]  = '{'h30, 'h20, 'h30, 'h20, 'h20, 'h10, 'h20, 'h10};
  int exp_c [12] = '{'h10, 'h20, 'h10, 'h20, 'h20, 'h30, 'h20, 'h30,
                     'h10, 'h20, 'h10, 'h20};

  initial begin
    int  budget;
    bit  hit;

    // Reset state
    reset = 1'b1; tb_en = 1'b0; tb_valid = 1'b0;
    tb_r = 8'h10; tb_g = 8'h20; tb_b = 8'h30;
    for (int n = 0; n < NI; n++) begin
      m_go[n] = 0; m_wcnt[n] = 0; m_idx[n] = 0; m_fc[n] = 0;
    end
    tick();
    tick();

    // Continuous valid, fixed colours: first-frame ordering per CFA phase
    reset = 1'b0; tb_en = 1'b1; tb_valid = 1'b1;
    collect = 1'b1;
    repeat (40) tick();
    collect = 1'b0;
    chk("seq_len", 0, (q_smp[0].size() >= 8)  ? 1 : 0, 1);
    chk("seq_len", 1, (q_smp[1].size() >= 8)  ? 1 : 0, 1);
    chk("seq_len", 2, (q_smp[2].size() >= 12) ? 1 : 0, 1);
    for (int i = 0; i < 8; i++) begin
      if (i < q_smp[0].size()) chk("seq_rggb", i, q_smp[0][i], exp_a[i]);
      if (i < q_smp[1].size()) chk("seq_bggr", i, q_smp[1][i], exp_b[i]);
    end
    for (int i = 0; i < 12; i++) begin
      if (i < q_smp[2].size()) chk("seq_nohb", i, q_smp[2][i], exp_c[i]);
    end

    // iValid toggling every cycle
    for (int i = 0; i < 60; i++) begin
      tb_valid = (i % 2 == 0);
      tick();
    end

    // Random valid / colours / occasional enable drop
    for (int i = 0; i < 300; i++) begin
      tb_valid = ($urandom_range(0, 3) != 0);
      tb_en    = ($urandom_range(0, 7) != 0);
      tb_r = 8'($urandom); tb_g = 8'($urandom); tb_b = 8'($urandom);
      tick();
    end

    // Reset on the 5th accepted pixel of instance 0
    tb_en = 1'b1; tb_valid = 1'b1;
    hit = 1'b0;
    budget = 200;
    while (!hit && budget > 0) begin
      if (e_ready[0] == 1 && m_idx[0] == 4) hit = 1'b1;
      else begin
        tick();
        budget--;
      end
    end
    if (!hit) begin
      n_tests++;
      n_fail++;
      $error("FAIL reset_point_timeout observed=%0d expected=%0d", budget, 1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (40) tick();

    // Enable dropped: every instance finishes its frame and parks in IDLE
    tb_en = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tb_valid = ($urandom_range(0, 3) != 0);
      tick();
    end
    for (int n = 0; n < NI; n++) chk("idle_ready", n, int'(obs_ready[n]), 0);
    tb_en = 1'b1; tb_valid = 1'b1;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bayer_stream_tx.md
Name: bayer_stream_tx

Overview:
- Transmit end of the processing input interface: converts a full-RGB pixel stream (test pattern generator or frame-buffer reader) into the raw 8-bit Bayer mosaic stream (newFrame / iValid / iData) that the processing pipeline consumes.
- Generates frame and line framing, horizontal/vertical blanking and end-of-frame signalling, so demosaic and filter-padding logic see a sensor-like stream in simulation and on board.

Parameters:
- width, 1920, active pixels per row.
- height, 1080, active rows per frame.
- hBlank, 16, idle cycles after each row except the last (0 allowed).
- vBlank, 64, idle cycles before each frame (must be >= 1).
- pattern, 0, CFA phase: 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- iEnable  in  1  allows a new frame to start.
- iValid  in  1  upstream RGB pixel valid.
- iR, iG, iB  in  8 each  upstream pixel components.
- oReady  out  1  upstream may present a pixel; transfer when iValid && oReady.
- oNewFrame  out  1  one-cycle pulse preceding the first pixel of a frame.
- oValid  out  1  Bayer sample valid.
- oData  out  8  Bayer sample.
- oDone  out  1  one-cycle pulse coincident with the last sample of a frame.
- oXCnt, oYCnt  out  16 each  column/row of the sample on oData.
- oFrameCnt  out  16  completed frames; wraps at 65535 -> 0.

Behaviour:
- Reset: all outputs 0; counters 0; state IDLE. Reset dominates every other event, including mid-frame; the partial frame is dropped and oFrameCnt is not incremented.
- States: IDLE, VBLANK, ACTIVE, HBLANK.
- IDLE: if iEnable, go to VBLANK, blankCnt=0.
- VBLANK: count vBlank cycles. oNewFrame=1 on the last one (blankCnt==vBlank-1). Then go to ACTIVE with x=0, y=0.
- ACTIVE: oReady=1 only in this state; combinational from state.
  - Accept (iValid && oReady): x advances.
  - Stall (iValid=0): x, y hold; oValid=0 next cycle.
  - On accepting x==width-1:
    - If y<height-1: go to HBLANK, or straight to ACTIVE with y+1 if hBlank==0.
    - If y==height-1: frame ends; oFrameCnt+1. Next state is VBLANK if iEnable, else IDLE.
- HBLANK: count hBlank cycles, then ACTIVE with x=0, y+1. iValid is ignored (oReady=0).
- Output register, latency 1 cycle from accept:
  - oValid<=accept; oXCnt/oYCnt<=x/y of the accepted pixel.
  - oData<=selected component; when not accepting, oData<=0.
- Colour select: px=x[0]^pattern[0], py=y[0]^pattern[1].
  - (py,px)=00 -> iR; 01 or 10 -> iG; 11 -> iB.
- oDone<=accept of pixel (width-1, height-1); it is high in the same cycle as that sample's oValid.
- No downstream backpressure; downstream must take every oValid sample.
- iEnable is sampled only in IDLE and at frame end; deasserting it mid-frame has no effect until frame end.
- Counter widths are sized for width, height <= 65535; x, y wrap to 0 at frame end.

Test Plan:
- width=4, height=2, hBlank=2, vBlank=3, pattern=0; iR=0x10, iG=0x20, iB=0x30; iValid=1; iEnable=1 -> after reset, oNewFrame on the 3rd cycle of VBLANK.
  - oData row0 = 10,20,10,20; then 2 idle cycles; row1 = 20,30,20,30.
  - oDone with the final 30; oFrameCnt=1; next oNewFrame exactly 3 cycles after frame end.
- Same config, pattern=3 -> row0 = 30,20,30,20; row1 = 20,10,20,10.
- Same config, iValid toggling 1,0 every cycle -> oReady stays 1 in ACTIVE.
  - Only accepted pixels emitted, in the same colour order.
  - oXCnt sequence 0,1,2,3 with gaps; no sample lost or duplicated.
- hBlank=0, width=4, height=3 -> 12 samples back-to-back with no gap between rows; oYCnt 0,0,0,0,1,...,2.
- Assert reset at the 5th accepted pixel -> all outputs 0 next cycle; oFrameCnt stays 0.
  - After release, a full new frame starts with oNewFrame and x=y=0.
- iEnable=0 at frame end -> state IDLE, oReady=0, no oNewFrame.
  - Raising iEnable starts VBLANK; oNewFrame pulses vBlank cycles later.
